// File: rtl/hrm_io_bridge_if.sv
// Signal bundle between the UART, the CPU mailboxes and the I/O bridge.
// The slave modport is the bridge view; master is the surrounding system.
interface hrm_io_bridge_if #(
    parameter int unsigned IBUF_LG = 2
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             clr_ovr;
    logic             cpu_in_full;
    logic [7:0]       cpu_in_data;
    logic             cpu_in_wr;
    logic             cpu_out_empty;
    logic [7:0]       cpu_out_data;
    logic             cpu_out_rd;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             rx_overrun;
    logic [IBUF_LG:0] ibuf_level;

    modport slave (
        input  rx_data, rx_valid, clr_ovr, cpu_in_full, cpu_out_empty, cpu_out_data, tx_ready,
        output cpu_in_data, cpu_in_wr, cpu_out_rd, tx_data, tx_start, rx_overrun, ibuf_level
    );

    modport master (
        output rx_data, rx_valid, clr_ovr, cpu_in_full, cpu_out_empty, cpu_out_data, tx_ready,
        input  cpu_in_data, cpu_in_wr, cpu_out_rd, tx_data, tx_start, rx_overrun, ibuf_level
    );
endinterface

// File: rtl/hrm_io_bridge.sv
// UART <-> CPU mailbox bridge: buffered inbound byte path and a 4-state outbound
// transmit sequencer. All outputs come straight from flops.
module hrm_io_bridge #(
    parameter int unsigned IBUF_LG = 2
) (
    input logic            clk,
    input logic            i_rst,
    hrm_io_bridge_if.slave bus
);
    localparam int unsigned Depth = 2 ** IBUF_LG;

    typedef enum logic [1:0] {StIdle, StPop, StSend, StWait} out_state_e;

    // Inbound path
    logic [7:0]         mem_q [Depth];
    logic [IBUF_LG-1:0] wr_ptr_q, rd_ptr_q;
    logic [IBUF_LG:0]   level_q, level_d;
    logic [7:0]         in_data_q;
    logic               in_wr_q;
    logic               overrun_q, overrun_d;
    logic               full, push, pop, drop;

    always_comb begin
        full = (level_q == (IBUF_LG+1)'(Depth));
        // Gating on in_wr_q limits INBOX writes to one every other cycle.
        pop  = (level_q != '0) && !bus.cpu_in_full && !in_wr_q;
        push = bus.rx_valid && (!full || pop);
        drop = bus.rx_valid && full && !pop;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (IBUF_LG+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (IBUF_LG+1)'(1);
        end

        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_data_q <= '0;
            in_wr_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            overrun_q <= overrun_d;
            in_wr_q   <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + IBUF_LG'(1);
            end
            if (pop) begin
                in_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + IBUF_LG'(1);
            end
        end
    end

    // Outbound path
    out_state_e state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       strobe_q;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.cpu_out_empty && bus.tx_ready) begin
                    state_d   = StPop;
                    tx_data_d = bus.cpu_out_data;
                end
            end
            StPop:  state_d = StSend;
            StSend: if (!bus.tx_ready) state_d = StWait;
            StWait: if (bus.tx_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= StIdle;
            tx_data_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            // Registered copy of "in POP" so the strobes are glitch-free flop outputs.
            strobe_q  <= (state_d == StPop);
        end
    end

    assign bus.cpu_in_data = in_data_q;
    assign bus.cpu_in_wr   = in_wr_q;
    assign bus.rx_overrun  = overrun_q;
    assign bus.ibuf_level  = level_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = strobe_q;
    assign bus.cpu_out_rd  = strobe_q;

endmodule

// File: tb/tb_hrm_io_bridge.sv
// Directed-vector bench for hrm_io_bridge: each task drives one scenario and
// checks its hand-computed results inline.
module tb_hrm_io_bridge;
    logic clk;
    logic i_rst;
    int   vectors;
    int   miscompares;

    hrm_io_bridge_if #(.IBUF_LG(2)) bus ();

    hrm_io_bridge #(.IBUF_LG(2)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst             = 1'b0;
        bus.rx_data       = 8'h00;
        bus.rx_valid      = 1'b0;
        bus.clr_ovr       = 1'b0;
        bus.cpu_in_full   = 1'b0;
        bus.cpu_out_empty = 1'b1;
        bus.cpu_out_data  = 8'h00;
        bus.tx_ready      = 1'b1;
        tick();
        tick();
        vectors++; if (bus.cpu_in_wr !== 1'b0) begin miscompares++; $display("FAIL rst_in_wr got %b exp 0", bus.cpu_in_wr); end
        vectors++; if (bus.cpu_out_rd !== 1'b0) begin miscompares++; $display("FAIL rst_out_rd got %b exp 0", bus.cpu_out_rd); end
        vectors++; if (bus.tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start got %b exp 0", bus.tx_start); end
        vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun got %b exp 0", bus.rx_overrun); end
        vectors++; if (bus.cpu_in_data !== 8'h00) begin miscompares++; $display("FAIL rst_in_data got %h exp 00", bus.cpu_in_data); end
        vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data got %h exp 00", bus.tx_data); end
        vectors++; if (bus.ibuf_level !== 3'd0) begin miscompares++; $display("FAIL rst_level got %0d exp 0", bus.ibuf_level); end
        i_rst = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        bus.rx_data  = 8'h41;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        vectors++; if (bus.ibuf_level !== 3'd1) begin miscompares++; $display("FAIL single_level1 got %0d exp 1", bus.ibuf_level); end
        vectors++; if (bus.cpu_in_wr !== 1'b0) begin miscompares++; $display("FAIL single_early_wr got %b exp 0", bus.cpu_in_wr); end
        tick();
        vectors++; if (bus.cpu_in_wr !== 1'b1) begin miscompares++; $display("FAIL single_wr got %b exp 1", bus.cpu_in_wr); end
        vectors++; if (bus.cpu_in_data !== 8'h41) begin miscompares++; $display("FAIL single_data got %h exp 41", bus.cpu_in_data); end
        vectors++; if (bus.ibuf_level !== 3'd0) begin miscompares++; $display("FAIL single_level0 got %0d exp 0", bus.ibuf_level); end
        tick();
        vectors++; if (bus.cpu_in_wr !== 1'b0) begin miscompares++; $display("FAIL single_wr_pulse got %b exp 0", bus.cpu_in_wr); end
    endtask

    task automatic test_overrun_fill();
        logic [7:0] got [8];
        int         n;
        bus.cpu_in_full = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.rx_data  = 8'(i);
            bus.rx_valid = 1'b1;
            tick();
        end
        bus.rx_valid = 1'b0;
        vectors++; if (bus.ibuf_level !== 3'd4) begin miscompares++; $display("FAIL ovr_level got %0d exp 4", bus.ibuf_level); end
        vectors++; if (bus.rx_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b exp 1", bus.rx_overrun); end
        vectors++; if (bus.cpu_in_wr !== 1'b0) begin miscompares++; $display("FAIL ovr_wr_while_full got %b exp 0", bus.cpu_in_wr); end
        bus.cpu_in_full = 1'b0;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (bus.cpu_in_wr === 1'b1 && n < 8) begin
                got[n] = bus.cpu_in_data;
                n++;
            end
        end
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL ovr_count got %0d exp 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            vectors++; if (got[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL ovr_order[%0d] got %h exp %h", i, got[i], 8'(i + 1)); end
        end
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %b exp 0", bus.rx_overrun); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] got [8];
        int         n;
        bus.cpu_in_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rx_data  = 8'h11 + 8'(i);
            bus.rx_valid = 1'b1;
            tick();
        end
        vectors++; if (bus.ibuf_level !== 3'd4) begin miscompares++; $display("FAIL pp_prefill got %0d exp 4", bus.ibuf_level); end
        bus.cpu_in_full = 1'b0;
        bus.rx_data     = 8'h15;
        bus.rx_valid    = 1'b1;
        tick();
        bus.rx_valid    = 1'b0;
        vectors++; if (bus.ibuf_level !== 3'd4) begin miscompares++; $display("FAIL pp_level got %0d exp 4", bus.ibuf_level); end
        vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("FAIL pp_overrun got %b exp 0", bus.rx_overrun); end
        vectors++; if (bus.cpu_in_wr !== 1'b1) begin miscompares++; $display("FAIL pp_wr got %b exp 1", bus.cpu_in_wr); end
        vectors++; if (bus.cpu_in_data !== 8'h11) begin miscompares++; $display("FAIL pp_data got %h exp 11", bus.cpu_in_data); end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.cpu_in_wr === 1'b1 && n < 8) begin
                got[n] = bus.cpu_in_data;
                n++;
            end
        end
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL pp_count got %0d exp 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            vectors++; if (got[i] !== 8'h12 + 8'(i)) begin miscompares++; $display("FAIL pp_order[%0d] got %h exp %h", i, got[i], 8'h12 + 8'(i)); end
        end
    endtask

    task automatic test_clr_priority();
        bus.cpu_in_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rx_data  = 8'h21 + 8'(i);
            bus.rx_valid = 1'b1;
            tick();
        end
        bus.rx_data  = 8'h25;
        bus.clr_ovr  = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        vectors++; if (bus.rx_overrun !== 1'b1) begin miscompares++; $display("FAIL clr_same_cycle got %b exp 1", bus.rx_overrun); end
        vectors++; if (bus.ibuf_level !== 3'd4) begin miscompares++; $display("FAIL clr_level got %0d exp 4", bus.ibuf_level); end
        tick();
        bus.clr_ovr = 1'b0;
        vectors++; if (bus.rx_overrun !== 1'b0) begin miscompares++; $display("FAIL clr_alone got %b exp 0", bus.rx_overrun); end
        bus.cpu_in_full = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        vectors++; if (bus.ibuf_level !== 3'd0) begin miscompares++; $display("FAIL clr_drain got %0d exp 0", bus.ibuf_level); end
    endtask

    task automatic test_outbound();
        int rds;
        int starts;
        bus.cpu_out_data  = 8'h7F;
        bus.cpu_out_empty = 1'b0;
        bus.tx_ready      = 1'b1;
        tick();
        vectors++; if (bus.cpu_out_rd !== 1'b1) begin miscompares++; $display("FAIL out_rd got %b exp 1", bus.cpu_out_rd); end
        vectors++; if (bus.tx_start !== 1'b1) begin miscompares++; $display("FAIL out_start got %b exp 1", bus.tx_start); end
        vectors++; if (bus.tx_data !== 8'h7F) begin miscompares++; $display("FAIL out_data got %h exp 7f", bus.tx_data); end
        bus.cpu_out_data = 8'h80;
        rds    = 0;
        starts = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            rds    += int'(bus.cpu_out_rd);
            starts += int'(bus.tx_start);
        end
        bus.tx_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            rds    += int'(bus.cpu_out_rd);
            starts += int'(bus.tx_start);
        end
        vectors++; if (bus.tx_data !== 8'h7F) begin miscompares++; $display("FAIL out_hold got %h exp 7f", bus.tx_data); end
        bus.tx_ready = 1'b1;
        tick();
        rds    += int'(bus.cpu_out_rd);
        starts += int'(bus.tx_start);
        vectors++; if (rds !== 0) begin miscompares++; $display("FAIL out_no_repop got %0d exp 0", rds); end
        vectors++; if (starts !== 0) begin miscompares++; $display("FAIL out_no_restart got %0d exp 0", starts); end
        vectors++; if (bus.tx_data !== 8'h7F) begin miscompares++; $display("FAIL out_hold_wait got %h exp 7f", bus.tx_data); end
        tick();
        vectors++; if (bus.cpu_out_rd !== 1'b1) begin miscompares++; $display("FAIL out_rd2 got %b exp 1", bus.cpu_out_rd); end
        vectors++; if (bus.tx_data !== 8'h80) begin miscompares++; $display("FAIL out_data2 got %h exp 80", bus.tx_data); end
        bus.cpu_out_empty = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        tick();
        bus.tx_ready = 1'b1;
        tick();
        tick();
        vectors++; if (bus.cpu_out_rd !== 1'b0) begin miscompares++; $display("FAIL out_empty_rd got %b exp 0", bus.cpu_out_rd); end
    endtask

    task automatic test_reset_mid();
        int strobes;
        bus.cpu_in_full   = 1'b1;
        bus.cpu_out_data  = 8'h55;
        bus.cpu_out_empty = 1'b0;
        bus.tx_ready      = 1'b1;
        bus.rx_data       = 8'h31;
        bus.rx_valid      = 1'b1;
        tick();
        bus.rx_data       = 8'h32;
        bus.cpu_out_empty = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        vectors++; if (bus.ibuf_level !== 3'd2) begin miscompares++; $display("FAIL mid_level got %0d exp 2", bus.ibuf_level); end
        vectors++; if (bus.tx_data !== 8'h55) begin miscompares++; $display("FAIL mid_tx_data got %h exp 55", bus.tx_data); end
        #2;
        i_rst = 1'b0;
        #1;
        vectors++; if (bus.ibuf_level !== 3'd0) begin miscompares++; $display("FAIL mid_rst_level got %0d exp 0", bus.ibuf_level); end
        vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_tx_data got %h exp 00", bus.tx_data); end
        vectors++; if ({bus.cpu_in_wr, bus.cpu_out_rd, bus.tx_start, bus.rx_overrun} !== 4'b0) begin miscompares++; $display("FAIL mid_rst_strobes got %b exp 0000", {bus.cpu_in_wr, bus.cpu_out_rd, bus.tx_start, bus.rx_overrun}); end
        tick();
        i_rst           = 1'b1;
        bus.cpu_in_full = 1'b0;
        strobes = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            strobes += int'(bus.cpu_in_wr) + int'(bus.cpu_out_rd) + int'(bus.tx_start);
        end
        vectors++; if (strobes !== 0) begin miscompares++; $display("FAIL mid_post_strobes got %0d exp 0", strobes); end
        vectors++; if (bus.ibuf_level !== 3'd0) begin miscompares++; $display("FAIL mid_post_level got %0d exp 0", bus.ibuf_level); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_byte();
        test_overrun_fill();
        test_push_pop_full();
        test_clr_priority();
        test_outbound();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hrm_io_bridge.md
HRM_IO_BRIDGE -- requirements
Module: hrm_io_bridge

Interface
REQ-001 SHALL have parameter IBUF_LG, default 2, giving an inbound buffer depth of 2**IBUF_LG bytes.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  in  1  reset: one clock, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have port rx_data  in  8  byte from the UART receiver.
REQ-005 SHALL have port rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port clr_ovr  in  1  clears rx_overrun.
REQ-007 SHALL have port cpu_in_full  in  1  CPU INBOX full.
REQ-008 SHALL have port cpu_in_data  out  8  byte pushed to the CPU INBOX.
REQ-009 SHALL have port cpu_in_wr  out  1  one-cycle INBOX write strobe.
REQ-010 SHALL have port cpu_out_empty  in  1  CPU OUTBOX empty.
REQ-011 SHALL have port cpu_out_data  in  8  OUTBOX head byte, valid whenever cpu_out_empty=0.
REQ-012 SHALL have port cpu_out_rd  out  1  one-cycle OUTBOX pop strobe.
REQ-013 SHALL have port tx_ready  in  1  UART transmitter idle.
REQ-014 SHALL have port tx_data  out  8  byte to transmit.
REQ-015 SHALL have port tx_start  out  1  one-cycle transmit strobe.
REQ-016 SHALL have port rx_overrun  out  1  sticky flag: an inbound byte was dropped.
REQ-017 SHALL have port ibuf_level  out  IBUF_LG+1  inbound buffer occupancy.

Function
REQ-018 SHALL drive every output from a register, with no combinational input-to-output path.
REQ-019 SHALL, on rx_valid=1 with the buffer not full, push rx_data at the write pointer (pointers wrap modulo depth).
REQ-020 SHALL, on rx_valid=1 with the buffer full and no pop in the same cycle, drop the byte and set rx_overrun=1.
REQ-021 SHALL, when a push and a pop occur in the same cycle, accept the push even if the buffer was full, leaving the level unchanged.
REQ-022 SHALL, when the buffer is non-empty and cpu_in_full=0 and cpu_in_wr was 0 in the previous cycle, register cpu_in_data=head and cpu_in_wr=1 for exactly one cycle, and pop the head at the same edge.
REQ-023 SHALL therefore deliver at most one INBOX write every two cycles; the first write occurs 2 cycles after an rx_valid into an empty buffer.
REQ-024 SHALL preserve byte order end-to-end, with no duplication and no loss except per REQ-020.
REQ-025 SHALL give clr_ovr priority below a same-cycle overrun event: rx_overrun stays 1.
REQ-026 SHALL keep ibuf_level consistent with pushes and pops every cycle, within 0..2**IBUF_LG.
REQ-027 SHALL implement the outbound FSM with states IDLE, POP, SEND, WAIT, encoded as 2 bits.
REQ-028 SHALL, in IDLE with cpu_out_empty=0 and tx_ready=1, capture tx_data<=cpu_out_data and go to POP.
REQ-029 SHALL, in POP, assert cpu_out_rd=1 and tx_start=1 for that single cycle and then go to SEND.
REQ-030 SHALL, in SEND, wait for tx_ready=0 and then go to WAIT.
REQ-031 SHALL, in WAIT, wait for tx_ready=1 and then go to IDLE.
REQ-032 SHALL hold tx_data stable from POP until leaving WAIT.
REQ-033 SHALL never assert cpu_out_rd while cpu_out_empty=1 or outside POP.
REQ-034 SHALL run the inbound and outbound paths independently, so that simultaneous activity does not stall either path.

Reset
REQ-035 SHALL, while i_rst=0, force cpu_in_wr=0, cpu_out_rd=0, tx_start=0, rx_overrun=0, cpu_in_data=0, tx_data=0, ibuf_level=0, both pointers=0 and the FSM to IDLE.
REQ-036 SHALL, on reset asserted mid-transfer, discard buffered bytes and the in-flight tx byte without issuing any further strobes.
REQ-037 SHALL take the first action no earlier than the first rising edge after i_rst returns to 1.

Verification
REQ-038 SHALL cover: rx_valid with 0x41 on an empty buffer, cpu_in_full=0 -> cpu_in_wr=1 with cpu_in_data=0x41 two cycles later, ibuf_level back to 0.
REQ-039 SHALL cover: cpu_in_full=1 and 5 bytes 0x01..0x05 received -> ibuf_level=4, rx_overrun=1, and after releasing full the INBOX receives 0x01..0x04 in order.
REQ-040 SHALL cover: OUTBOX holds 0x7F with tx_ready=1 -> exactly one cpu_out_rd and one tx_start in the same cycle with tx_data=0x7F, and no new pop until tx_ready goes 0 then 1.
REQ-041 SHALL cover: a full buffer with a same-cycle rx_valid and pop -> byte accepted, rx_overrun stays 0, level stays 4.
REQ-042 SHALL cover: i_rst=0 asserted in SEND with 2 bytes buffered -> all outputs 0 immediately and no strobes after release until new input.
REQ-043 SHALL cover: clr_ovr=1 in the same cycle as an overrun -> rx_overrun=1; clr_ovr=1 alone the next cycle -> rx_overrun=0.
